// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 program-counter unit.
//   pc_sel_t  : the eight PC-select codes carried by the control word
//   LEGV8_INC : sequential instruction increment in bytes
package legv8_pkg;

    typedef enum logic [2:0] {
        PS_HOLD     = 3'b000,
        PS_SEQ      = 3'b001,
        PS_ABS      = 3'b010,
        PS_REL      = 3'b011,
        PS_CALL_REL = 3'b100,
        PS_CALL_ABS = 3'b101,
        PS_RET      = 3'b110,
        PS_RSVD     = 3'b111
    } pc_sel_t;

    localparam int LEGV8_INC = 4;

endpackage

// File: rtl/legv8_ras.sv
// Circular return-address stack.
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, pop       : stack operations (push takes priority if both are set)
//   push_data       : value written on push
//   top_data        : most recently pushed valid entry
//   count           : number of valid entries (saturates at DEPTH)
//   full, empty     : count == DEPTH / count == 0
//   ovf_pulse       : push while full (oldest entry was overwritten)
//   udf_pulse       : pop while empty (nothing changed)
module legv8_ras #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             ovf_pulse,
    output logic             udf_pulse
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q;    // next slot to write; top entry sits just below it
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] ptr_inc_s;
    logic [PTR_W-1:0] ptr_dec_s;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             wr_en_s;

    assign ptr_inc_s = (ptr_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : ptr_q + PTR_W'(1);
    assign ptr_dec_s = (ptr_q == {PTR_W{1'b0}}) ? PTR_W'(DEPTH - 1) : ptr_q - PTR_W'(1);

    assign top_data = mem_q[ptr_dec_s];
    assign count    = count_q;
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == {CNT_W{1'b0}});

    // Next pointer/count. When full, the write slot is the oldest entry, so
    // an overflowing push naturally discards it.
    always_comb begin
        ptr_d     = ptr_q;
        count_d   = count_q;
        wr_en_s   = 1'b0;
        ovf_pulse = 1'b0;
        udf_pulse = 1'b0;
        if (push) begin
            wr_en_s = 1'b1;
            ptr_d   = ptr_inc_s;
            if (full) begin
                ovf_pulse = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop) begin
            if (empty) begin
                udf_pulse = 1'b1;
            end else begin
                ptr_d   = ptr_dec_s;
                count_d = count_q - CNT_W'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Stack storage; contents are meaningless until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/legv8_pc_unit.sv
// LEGv8 program-counter unit: PC register, next-PC mux, word alignment,
// and call/return support through an internal return-address stack.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   en           : PC update enable (control-word PC-load bit)
//   ps           : PC-select mode (see legv8_pkg::pc_sel_t)
//   target       : absolute target or signed offset
//   err_clr      : clears sticky ovf/udf (a same-cycle new error wins)
//   pc           : current PC (registered)
//   pc_next_seq  : pc + INC (combinational)
//   ras_count, ras_empty, ras_full : stack occupancy
//   ovf, udf     : sticky push-while-full / pop-while-empty flags
module legv8_pc_unit
    import legv8_pkg::*;
#(
    parameter int                  PC_WIDTH     = 64,
    parameter int                  RAS_DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                  INC          = LEGV8_INC
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             en,
    input  logic [2:0]                       ps,
    input  logic [PC_WIDTH-1:0]              target,
    input  logic                             err_clr,
    output logic [PC_WIDTH-1:0]              pc,
    output logic [PC_WIDTH-1:0]              pc_next_seq,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_empty,
    output logic                             ras_full,
    output logic                             ovf,
    output logic                             udf
);

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [PC_WIDTH-1:0] raw_next_s;
    logic [PC_WIDTH-1:0] ras_top_s;
    logic                push_s;
    logic                pop_s;
    logic                ras_ovf_s;
    logic                ras_udf_s;
    logic                ovf_q;
    logic                ovf_d;
    logic                udf_q;
    logic                udf_d;
    pc_sel_t             ps_s;

    assign ps_s        = pc_sel_t'(ps);
    assign pc          = pc_q;
    assign pc_next_seq = pc_q + PC_WIDTH'(INC);
    assign ovf         = ovf_q;
    assign udf         = udf_q;

    legv8_ras #(
        .WIDTH (PC_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clock),
        .rst_n     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_next_seq),
        .top_data  (ras_top_s),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty),
        .ovf_pulse (ras_ovf_s),
        .udf_pulse (ras_udf_s)
    );

    // Next-PC selection, stack requests, alignment and sticky-flag update.
    always_comb begin
        raw_next_s = pc_q;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        if (en) begin
            case (ps_s)
                PS_HOLD:     raw_next_s = pc_q;
                PS_SEQ:      raw_next_s = pc_next_seq;
                PS_ABS:      raw_next_s = target;
                PS_REL:      raw_next_s = pc_q + target;
                PS_CALL_REL: begin
                    push_s     = 1'b1;
                    raw_next_s = pc_q + target;
                end
                PS_CALL_ABS: begin
                    push_s     = 1'b1;
                    raw_next_s = target;
                end
                PS_RET: begin
                    // Pop is still requested when empty so the stack reports underflow.
                    pop_s = 1'b1;
                    if (ras_empty) begin
                        raw_next_s = pc_q;
                    end else begin
                        raw_next_s = ras_top_s;
                    end
                end
                default:     raw_next_s = pc_q;
            endcase
        end else begin
            raw_next_s = pc_q;
        end
        pc_d  = {raw_next_s[PC_WIDTH-1:2], 2'b00};
        ovf_d = ras_ovf_s | (ovf_q & ~err_clr);
        udf_d = ras_udf_s | (udf_q & ~err_clr);
    end

    // PC and sticky error flag registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_VECTOR;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

endmodule

// File: tb/tb_legv8_pc_unit.sv
module tb_legv8_pc_unit;

    localparam logic [2:0] PS_HOLD     = 3'b000;
    localparam logic [2:0] PS_SEQ      = 3'b001;
    localparam logic [2:0] PS_ABS      = 3'b010;
    localparam logic [2:0] PS_REL      = 3'b011;
    localparam logic [2:0] PS_CALL_REL = 3'b100;
    localparam logic [2:0] PS_CALL_ABS = 3'b101;
    localparam logic [2:0] PS_RET      = 3'b110;

    logic        clock;
    logic        reset;
    logic        en;
    logic [2:0]  ps;
    logic [63:0] target;
    logic        err_clr;
    logic [63:0] pc;
    logic [63:0] pc_next_seq;
    logic [2:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;
    logic        ovf;
    logic        udf;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    legv8_pc_unit #(
        .PC_WIDTH     (64),
        .RAS_DEPTH    (4),
        .RESET_VECTOR (64'h100),
        .INC          (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .ps          (ps),
        .target      (target),
        .err_clr     (err_clr),
        .pc          (pc),
        .pc_next_seq (pc_next_seq),
        .ras_count   (ras_count),
        .ras_empty   (ras_empty),
        .ras_full    (ras_full),
        .ovf         (ovf),
        .udf         (udf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; ps = PS_HOLD; target = 64'h0; err_clr = 1'b0;
        step();
        chk_cnt++; if (pc !== 64'h100) $display("FAIL reset_pc: got %h want %h", pc, 64'h100); else pass_cnt++;
        chk_cnt++; if (pc_next_seq !== 64'h104) $display("FAIL reset_nseq: got %h want %h", pc_next_seq, 64'h104); else pass_cnt++;
        chk_cnt++; if ({ras_count, ras_empty, ras_full, ovf, udf} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_ras: got cnt=%0d e=%b f=%b o=%b u=%b want cnt=0 e=1 f=0 o=0 u=0",
                     ras_count, ras_empty, ras_full, ovf, udf);
        else pass_cnt++;
        reset = 1'b1;
    endtask

    task automatic test_seq();
        logic [63:0] exp_pc [3];
        exp_pc[0] = 64'h104; exp_pc[1] = 64'h108; exp_pc[2] = 64'h10C;
        en = 1'b1; ps = PS_SEQ;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_cnt++; if (pc !== exp_pc[i]) $display("FAIL seq_%0d: got %h want %h", i, pc, exp_pc[i]); else pass_cnt++;
        end
    endtask

    task automatic test_call_ret();
        ps = PS_ABS; target = 64'h200; step();
        chk_cnt++; if (pc !== 64'h200) $display("FAIL cr_abs: got %h want %h", pc, 64'h200); else pass_cnt++;
        ps = PS_CALL_REL; target = 64'h40; step();
        chk_cnt++; if (pc !== 64'h240) $display("FAIL cr_call_pc: got %h want %h", pc, 64'h240); else pass_cnt++;
        chk_cnt++; if (ras_count !== 3'd1) $display("FAIL cr_call_cnt: got %0d want 1", ras_count); else pass_cnt++;
        ps = PS_RET; step();
        chk_cnt++; if (pc !== 64'h204) $display("FAIL cr_ret_pc: got %h want %h", pc, 64'h204); else pass_cnt++;
        chk_cnt++; if ({ras_count, ras_empty} !== {3'd0, 1'b1})
            $display("FAIL cr_ret_ras: got cnt=%0d e=%b want cnt=0 e=1", ras_count, ras_empty);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [63:0] exp_ret [5];
        exp_ret[0] = 64'h44; exp_ret[1] = 64'h34; exp_ret[2] = 64'h24;
        exp_ret[3] = 64'h14; exp_ret[4] = 64'h14;
        ps = PS_ABS; target = 64'h0; step();
        for (int i = 0; i < 5; i++) begin
            ps = PS_CALL_ABS; target = 64'(i + 1) * 64'h10; step();
            chk_cnt++; if (pc !== 64'(i + 1) * 64'h10) $display("FAIL ovf_call_%0d: got %h want %h", i, pc, 64'(i + 1) * 64'h10); else pass_cnt++;
        end
        chk_cnt++; if ({ovf, ras_full, ras_count} !== {1'b1, 1'b1, 3'd4})
            $display("FAIL ovf_flags: got o=%b f=%b cnt=%0d want o=1 f=1 cnt=4", ovf, ras_full, ras_count);
        else pass_cnt++;
        ps = PS_RET;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_cnt++; if (pc !== exp_ret[i]) $display("FAIL ret_%0d: got %h want %h", i, pc, exp_ret[i]); else pass_cnt++;
            chk_cnt++; if (udf !== (i == 4)) $display("FAIL ret_udf_%0d: got %b want %b", i, udf, (i == 4)); else pass_cnt++;
        end
        chk_cnt++; if ({ras_count, ras_empty} !== {3'd0, 1'b1})
            $display("FAIL udf_ras: got cnt=%0d e=%b want cnt=0 e=1", ras_count, ras_empty);
        else pass_cnt++;
    endtask

    task automatic test_enable_errclr();
        // pc = 0x14, stack empty, ovf = udf = 1 on entry
        en = 1'b0; ps = PS_CALL_ABS; target = 64'h999; step();
        chk_cnt++; if ({pc, ras_count} !== {64'h14, 3'd0})
            $display("FAIL en0_hold: got pc=%h cnt=%0d want pc=14 cnt=0", pc, ras_count);
        else pass_cnt++;
        err_clr = 1'b1; step();
        chk_cnt++; if ({udf, ovf} !== 2'b00) $display("FAIL errclr_en0: got u=%b o=%b want u=0 o=0", udf, ovf); else pass_cnt++;
        en = 1'b1; ps = PS_RET; step();
        chk_cnt++; if (udf !== 1'b1) $display("FAIL errclr_vs_udf: got %b want 1", udf); else pass_cnt++;
        chk_cnt++; if (pc !== 64'h14) $display("FAIL errclr_ret_pc: got %h want %h", pc, 64'h14); else pass_cnt++;
        ps = PS_HOLD; step();
        chk_cnt++; if (udf !== 1'b0) $display("FAIL errclr_hold: got %b want 0", udf); else pass_cnt++;
        err_clr = 1'b0;
    endtask

    task automatic test_wrap();
        ps = PS_ABS; target = 64'hFFFF_FFFF_FFFF_FFFC; step();
        chk_cnt++; if (pc_next_seq !== 64'h0) $display("FAIL wrap_nseq: got %h want 0", pc_next_seq); else pass_cnt++;
        ps = PS_SEQ; step();
        chk_cnt++; if (pc !== 64'h0) $display("FAIL wrap_seq: got %h want 0", pc); else pass_cnt++;
        ps = PS_ABS; target = 64'h10; step();
        ps = PS_REL; target = 64'hFFFF_FFFF_FFFF_FFF8; step();
        chk_cnt++; if (pc !== 64'h8) $display("FAIL rel_neg: got %h want %h", pc, 64'h8); else pass_cnt++;
        ps = PS_ABS; target = 64'h123; step();
        chk_cnt++; if (pc !== 64'h120) $display("FAIL abs_align: got %h want %h", pc, 64'h120); else pass_cnt++;
        ps = PS_REL; target = 64'h7; step();
        chk_cnt++; if (pc !== 64'h124) $display("FAIL rel_align: got %h want %h", pc, 64'h124); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        ps = PS_ABS; target = 64'h300; step();
        ps = PS_CALL_ABS; target = 64'h400; step();
        ps = PS_CALL_ABS; target = 64'h500; step();
        chk_cnt++; if ({pc, ras_count} !== {64'h500, 3'd2})
            $display("FAIL ar_pre: got pc=%h cnt=%0d want pc=500 cnt=2", pc, ras_count);
        else pass_cnt++;
        ps = PS_RET;
        #2 reset = 1'b0;
        #1;
        chk_cnt++; if ({pc, ras_count, ras_empty} !== {64'h100, 3'd0, 1'b1})
            $display("FAIL ar_now: got pc=%h cnt=%0d e=%b want pc=100 cnt=0 e=1", pc, ras_count, ras_empty);
        else pass_cnt++;
        step();
        reset = 1'b1; ps = PS_SEQ; step();
        chk_cnt++; if (pc !== 64'h104) $display("FAIL ar_first: got %h want %h", pc, 64'h104); else pass_cnt++;
        ps = PS_RET; step();
        chk_cnt++; if ({pc, udf} !== {64'h104, 1'b1})
            $display("FAIL ar_ret: got pc=%h u=%b want pc=104 u=1", pc, udf);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_seq();
        test_call_ret();
        test_overflow();
        test_enable_errclr();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/legv8_pc_unit.md
# legv8_pc_unit

Parametrised program-counter unit for the LEGv8 datapath. It replaces the fixed hold / +4 / load / relative PC path with a width-generic PC register. It adds call and return modes backed by an internal return-address stack (RAS) with overflow and underflow reporting. It sits between the control-word decoder (PC-select field) and the instruction-address bus.

## Interface
Parameters:
- `PC_WIDTH`, 64: PC and target width, minimum 8.
- `RAS_DEPTH`, 4: number of return-address stack entries, minimum 1.
- `RESET_VECTOR`, 0: PC value after reset; bits [1:0] must be 0.
- `INC`, 4: sequential increment.

Ports:
- `clock`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-low reset. 0 = reset asserted.
- `en`, in, 1: PC update enable, taken from the control-word PC-load bit.
- `ps`, in, 3: PC-select mode.
- `target`, in, `PC_WIDTH`: absolute target or signed offset. Source is the register/constant bus.
- `err_clr`, in, 1: clears sticky error flags.
- `pc`, out, `PC_WIDTH`: current PC (registered).
- `pc_next_seq`, out, `PC_WIDTH`: `pc + INC` (combinational).
- `ras_count`, out, `$clog2(RAS_DEPTH+1)`: number of valid stack entries.
- `ras_empty`, out, 1: high when `ras_count` == 0.
- `ras_full`, out, 1: high when `ras_count` == `RAS_DEPTH`.
- `ovf`, out, 1: sticky flag, push while full.
- `udf`, out, 1: sticky flag, pop while empty.

## Operation
- `ps` encoding:
  - 000 HOLD
  - 001 SEQ: `pc + INC`
  - 010 ABS: `target`
  - 011 REL: `pc + target`
  - 100 CALL_REL: push `pc + INC`, then `pc + target`
  - 101 CALL_ABS: push `pc + INC`, then `target`
  - 110 RET: pop into `pc`
  - 111 reserved, behaves as HOLD.
- All arithmetic is modulo 2^`PC_WIDTH`. Wrap-around is silent.
- Every new PC value has bits [1:0] forced to 0, including popped values.
- When `en` = 0, the PC, the stack and `ras_count` hold; `ps` is ignored.
- Push while full: the oldest entry is discarded (circular stack), the new entry becomes top, `ras_count` stays at `RAS_DEPTH`, and `ovf` sets. The PC still moves to the call target.
- Pop while empty: `pc` holds, `ras_count` stays 0, and `udf` sets.
- `err_clr` works independently of `en`. If `err_clr` and a new error occur in the same cycle, the error wins and the flag stays set.
- Stack contents are not cleared on pop. Only `ras_count` and the top pointer change.

## Timing
- Reset (asynchronous, while `reset` = 0): `pc` = `RESET_VECTOR`, `ras_count` = 0, `ovf` = `udf` = 0, top pointer = 0. Stack RAM contents are don't-care.
- `ras_empty` = 1 and `ras_full` = 0 during reset, or `ras_full` = 1 if `RAS_DEPTH` = 0 (illegal, not supported).
- Reset asserted mid-sequence discards any in-flight call or return. The first edge after release is a normal update.
- Latency: one cycle. Mode and `target` sampled at edge N appear on `pc`, `ras_count` and the flags after edge N.
- `pc_next_seq` follows `pc` combinationally with zero latency.
- Back-to-back CALL then RET on consecutive cycles returns to the caller's `pc + INC`. No bubble is required.

## Structure
- `legv8_pkg`: `pc_sel_t` enum (the eight `ps` codes) and `LEGV8_INC` = 4.
- Sub-module `legv8_ras`:
  - Parameterised by width and depth.
  - Inputs: push, pop, push data.
  - Outputs: top data, count, full, empty, ovf and udf pulses.
  - Circular storage with a top pointer.
- The top level owns the PC register, next-PC mux, alignment masking and sticky flags.

## Test plan
- Reset with `RESET_VECTOR` = 0x100, then release with `en` = 1 and `ps` = SEQ for 3 cycles: `pc` = 0x104, 0x108, 0x10C.
- `pc` = 0x200, CALL_REL with `target` = 0x40: `pc` = 0x240, `ras_count` = 1. Then RET: `pc` = 0x204, `ras_count` = 0, `ras_empty` = 1.
- `RAS_DEPTH` = 4, five nested CALL_ABS from `pc` values 0x0, 0x10, 0x20, 0x30, 0x40: `ovf` = 1, `ras_full` = 1. Five RETs return 0x44, 0x34, 0x24, 0x14, then the fifth holds with `udf` = 1.
- `pc` = 0xFFFF_FFFF_FFFF_FFFC, SEQ: `pc` = 0. REL with `target` = -8 from 0x10: `pc` = 0x8. ABS with `target` = 0x123: `pc` = 0x120.
- `en` = 0 with `ps` = CALL_ABS: `pc` and `ras_count` unchanged. `err_clr` = 1 while `udf` = 1 and `en` = 0: `udf` clears. `err_clr` together with a RET on an empty stack: `udf` stays 1.
- Assert `reset` = 0 asynchronously mid-cycle after two CALLs: `pc` = `RESET_VECTOR` and `ras_count` = 0 immediately, without waiting for a clock edge.
